sumador_acumulador: RTL
=======================

# sumador_acumulador

Registered, parametrised two's-complement adder/subtractor with an internal accumulator, selectable saturation and a valid/ready handshake on both sides. It extends the plain combinational subtractor used in lab datapaths with four operations, overflow detection and sign/zero flags. It is intended to sit between a stimulus source (switch/FSM front end) and a display or downstream datapath stage.

## Interface
- `WIDTH`, default 10: operand/result width in bits, signed two's complement; legal range 2..32.
- `SAT`, default 1: 1 = saturate on overflow; 0 = wrap modulo 2^WIDTH.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: operand set presented.
- `in_ready` output, 1 bit: block can accept an operand set this cycle.
- `op` input, 2 bits: 00 = A+B, 01 = A−B, 10 = ACC+A, 11 = ACC−A.
- `a`, `b` input, signed WIDTH bits: operands; `b` is ignored for op 1x.
- `clr` input, 1 bit: synchronous clear of accumulator and sticky flag.
- `out_valid` output, 1 bit: result registered and pending.
- `out_ready` input, 1 bit: consumer accepts the result.
- `res` output, signed WIDTH bits: result.
- `ovf` output, 1 bit: overflow occurred on this result.
- `neg` output, 1 bit: `res[WIDTH-1]`.
- `zero` output, 1 bit: `res == 0`.
- `ovf_sticky` output, 1 bit: OR of `ovf` over all accepted results since the last reset or `clr`.

## Operation
- Accept: `in_valid && in_ready`. Deliver: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`, so a new operand set can be accepted in the same cycle the previous result is delivered.
- Each operation computes the full result at WIDTH+1 bits. Overflow occurs when the two top bits of that WIDTH+1-bit sum differ.
- `SAT=1`: on overflow, `res` is the maximum positive value (0111…1) if the true result is positive, otherwise the minimum negative value (1000…0). `SAT=0`: `res` is the low WIDTH bits.
- `neg` and `zero` are derived from the final `res`, after saturation.
- Accumulator ACC (WIDTH bits, reset 0):
  - Ops 10 and 11 use the current ACC as the first operand.
  - On accept of op 10 or 11, ACC loads the final `res`.
  - Ops 00 and 01 leave ACC unchanged.
- `clr`:
  - Sets ACC to 0 and `ovf_sticky` to 0 at the next edge.
  - If `clr` and an op-1x accept occur in the same cycle, the op uses ACC = 0 and ACC loads its result. `clr` therefore acts as "start a new sum".
  - `clr` does not affect `out_valid` or `res`.
- Output register holds `res`, `ovf`, `neg` and `zero` stable while `out_valid && !out_ready`.
- Effective state: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on accept.
  - FULL→FULL on simultaneous deliver and accept (new data loaded).
  - FULL→EMPTY on deliver without accept.
  - FULL holds on no deliver.

## Timing
- Latency: 1 cycle. An operand set accepted at edge n appears on `res` with `out_valid=1` after edge n.
- Throughput: 1 result per cycle while `out_ready=1`.
- Reset values: `out_valid=0`, `res=0`, `ovf=0`, `neg=0`, `zero=1`, `ovf_sticky=0`, ACC = 0. `in_ready=1` follows combinationally from `out_valid=0`.
- Reset mid-operation: any pending result is discarded and no deliver is signalled.
- `in_ready` depends combinationally on `out_ready`. This is the only input-to-output combinational path.
- `ovf_sticky` is set at the same edge that registers an overflowing result.

## Structure
- Shared package `sumador_pkg`:
  - op encoding constants `OP_ADD`, `OP_SUB`, `OP_ACC_ADD`, `OP_ACC_SUB`.
  - function or macros for WIDTH-dependent `MAX_POS` / `MIN_NEG`.
- One sub-module, `sat_addsub`:
  - combinational; inputs x, y, sub; outputs res, ovf.
  - parametrised on WIDTH and SAT.
  - instantiated once; the operand mux for x (`a` or ACC) sits in the top level.

## Test plan
- Reset then idle (WIDTH=10): `out_valid=0`, `zero=1`, `in_ready=1`. Then op 00, a=100, b=−30 → after 1 cycle `res=70`, `ovf=0`, `neg=0`.
- Overflow, SAT=1: op 00, a=500, b=20 → `res=511`, `ovf=1`, `ovf_sticky=1`. Op 01, a=−500, b=20 → `res=−512`, `neg=1`.
- Overflow, SAT=0: op 00, a=500, b=20 → `res=−504`, `ovf=1`.
- Accumulate:
  - `clr`+op 10 a=5, then op 10 a=7, then op 11 a=20 → results 5, 12, −8, ACC=−8.
  - A following op 00 leaves ACC at −8.
- Backpressure: hold `out_ready=0` with `in_valid=1` for 3 cycles → `in_ready=0`, `res` stable, one accept only. Raise `out_ready` → back-to-back results every cycle with none lost or duplicated.
- Async reset asserted while `out_valid=1` and ACC=42 → `out_valid` and ACC go to 0 immediately, without waiting for a clock edge. The first op 10, a=1, after release → `res=1`.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared op encoding, handshake state type and width-dependent saturation limits
// for the registered adder/accumulator.
package sumador_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Limits returned in a 32-bit container; callers truncate to their width.
    function automatic logic [31:0] max_pos(input int unsigned width);
        return (32'd1 << (width - 32'd1)) - 32'd1;
    endfunction

    function automatic logic [31:0] min_neg(input int unsigned width);
        return 32'd1 << (width - 32'd1);
    endfunction

endpackage

// File: rtl/sat_addsub.sv
// Combinational two's-complement add/subtract with overflow detection and
// optional saturation to the signed limits.
module sat_addsub
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter bit          SAT   = 1'b1
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] res,
    output logic                    ovf
);

    localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] y_ext;
    logic [WIDTH:0] full;

    // Sign-extend by one bit so the true result always fits; the top two
    // bits disagree exactly when the WIDTH-bit result would overflow.
    always_comb begin
        x_ext = {x[WIDTH-1], x};
        y_ext = {y[WIDTH-1], y};
        full  = sub ? (x_ext - y_ext) : (x_ext + y_ext);
        ovf   = full[WIDTH] ^ full[WIDTH-1];
        res   = full[WIDTH-1:0];
        if (SAT && ovf) begin
            res = full[WIDTH] ? MIN_NEG : MAX_POS;
        end
    end

endmodule

// File: rtl/sumador_acumulador.sv
// Registered adder/subtractor with accumulator, sticky overflow flag and a
// one-deep valid/ready output stage.
module sumador_acumulador
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter bit          SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] res,
    output logic                    ovf,
    output logic                    neg,
    output logic                    zero,
    output logic                    ovf_sticky
);

    state_t                  state_q;
    state_t                  state_d;
    logic                    accept;
    logic                    acc_op;
    logic                    sub;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] x_sel;
    logic signed [WIDTH-1:0] y_sel;
    logic signed [WIDTH-1:0] sum_res;
    logic                    sum_ovf;

    assign out_valid = (state_q == ST_FULL);

    // Handshake and output-stage occupancy.
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == ST_EMPTY) || out_ready;
        accept   = in_valid && in_ready;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)         state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Operand selection; a same-cycle clr makes the accumulator read as zero.
    always_comb begin
        acc_op = (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
        sub    = (op == OP_SUB) || (op == OP_ACC_SUB);
        x_sel  = a;
        y_sel  = b;
        if (acc_op) begin
            x_sel = clr ? '0 : acc;
            y_sel = a;
        end
    end

    sat_addsub #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_sat_addsub (
        .x   (x_sel),
        .y   (y_sel),
        .sub (sub),
        .res (sum_res),
        .ovf (sum_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Result register only loads on accept, so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res  <= '0;
            ovf  <= 1'b0;
            neg  <= 1'b0;
            zero <= 1'b1;
        end else if (accept) begin
            res  <= sum_res;
            ovf  <= sum_ovf;
            neg  <= sum_res[WIDTH-1];
            zero <= (sum_res == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && acc_op) begin
            acc <= sum_res;
        end else if (clr) begin
            acc <= '0;
        end
    end

    // A clr restarts the sticky history, counting only the result accepted with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (clr) begin
            ovf_sticky <= accept && sum_ovf;
        end else if (accept && sum_ovf) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule
